// File: rtl/fp32_to_int.sv
// fp32_to_int: sequential IEEE-754 single to signed 32-bit integer converter.
// The mantissa is aligned by a one-bit-per-cycle shifter. The result is truncated
// toward zero, and the Exception/Overflow/Underflow flags match the forward converter.
module fp32_to_int (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fp_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        Exception,
  output logic        Overflow,
  output logic        Underflow
);

  typedef enum logic [1:0] {StIdle, StShift, StPack, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] work_q, work_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        left_q, left_d;
  logic        sign_q, sign_d;
  logic        special_q, special_d;
  logic [31:0] spec_val_q, spec_val_d;
  logic        p_exc_q, p_exc_d;
  logic        p_ovf_q, p_ovf_d;
  logic        p_unf_q, p_unf_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;

  logic [7:0]  in_exp;
  logic [22:0] in_frac;
  logic        in_sign;
  logic [31:0] sat_val;
  logic        c_special, c_exc, c_ovf, c_unf, c_left;
  logic [31:0] c_val;
  logic [7:0]  c_shift;

  assign in_sign = fp_in[31];
  assign in_exp  = fp_in[30:23];
  assign in_frac = fp_in[22:0];
  assign sat_val = in_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;

  // Classify the incoming float and derive the shift count and direction.
  always_comb begin
    c_special = 1'b0;
    c_val     = 32'h0;
    c_exc     = 1'b0;
    c_ovf     = 1'b0;
    c_unf     = 1'b0;
    c_left    = 1'b0;
    c_shift   = 8'd0;
    if (in_exp == 8'd255) begin
      c_special = 1'b1;
      c_exc     = 1'b1;
      if (in_frac == 23'd0) begin
        c_val = sat_val;
        c_ovf = 1'b1;
      end
    end else if (in_exp == 8'd0) begin
      c_special = 1'b1;
      c_unf     = (in_frac != 23'd0);
    end else if (in_exp <= 8'd126) begin
      c_special = 1'b1;
      c_unf     = 1'b1;
    end else if (in_exp >= 8'd158) begin
      c_special = 1'b1;
      // -2^31 is the only representable value at this magnitude.
      if (in_exp == 8'd158 && in_sign && in_frac == 23'd0) begin
        c_val = 32'h8000_0000;
      end else begin
        c_val = sat_val;
        c_ovf = 1'b1;
      end
    end else if (in_exp <= 8'd150) begin
      c_shift = 8'd150 - in_exp;
    end else begin
      c_left  = 1'b1;
      c_shift = in_exp - 8'd150;
    end
  end

  // Next-state logic for the control FSM and the datapath registers.
  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    cnt_d      = cnt_q;
    left_d     = left_q;
    sign_d     = sign_q;
    special_d  = special_q;
    spec_val_d = spec_val_q;
    p_exc_d    = p_exc_q;
    p_ovf_d    = p_ovf_q;
    p_unf_d    = p_unf_q;
    result_d   = result_q;
    exc_d      = exc_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          work_d     = {8'h00, 1'b1, in_frac};
          cnt_d      = c_shift[4:0];
          left_d     = c_left;
          sign_d     = in_sign;
          special_d  = c_special;
          spec_val_d = c_val;
          p_exc_d    = c_exc;
          p_ovf_d    = c_ovf;
          p_unf_d    = c_unf;
          state_d    = (c_shift != 8'd0) ? StShift : StPack;
        end
      end
      StShift: begin
        work_d = left_q ? {work_q[30:0], 1'b0} : {1'b0, work_q[31:1]};
        cnt_d  = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = StPack;
      end
      StPack: begin
        if (special_q)   result_d = spec_val_q;
        else if (sign_q) result_d = ~work_q + 32'd1;
        else             result_d = work_q;
        exc_d   = p_exc_q;
        ovf_d   = p_ovf_q;
        unf_d   = p_unf_q;
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      work_q     <= 32'h0;
      cnt_q      <= 5'd0;
      left_q     <= 1'b0;
      sign_q     <= 1'b0;
      special_q  <= 1'b0;
      spec_val_q <= 32'h0;
      p_exc_q    <= 1'b0;
      p_ovf_q    <= 1'b0;
      p_unf_q    <= 1'b0;
      result_q   <= 32'h0;
      exc_q      <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      cnt_q      <= cnt_d;
      left_q     <= left_d;
      sign_q     <= sign_d;
      special_q  <= special_d;
      spec_val_q <= spec_val_d;
      p_exc_q    <= p_exc_d;
      p_ovf_q    <= p_ovf_d;
      p_unf_q    <= p_unf_d;
      result_q   <= result_d;
      exc_q      <= exc_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign Exception = exc_q;
  assign Overflow  = ovf_q;
  assign Underflow = unf_q;

endmodule

// File: tb/tb_fp32_to_int.sv
// Self-checking bench for fp32_to_int: directed vector table plus handshake/reset sequences.
module tb_fp32_to_int;

  logic        clk;
  logic        rst;
  logic [31:0] fp_in;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] result;
  logic        out_valid;
  logic        out_ready;
  logic        Exception;
  logic        Overflow;
  logic        Underflow;

  int total;
  int bad;

  fp32_to_int dut (
    .clk       (clk),
    .rst       (rst),
    .fp_in     (fp_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Exception (Exception),
    .Overflow  (Overflow),
    .Underflow (Underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] fp;
    logic [31:0] res;
    logic [2:0]  flags;  // {Exception, Overflow, Underflow}
    int          lat;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present one float, wait for out_valid (bounded), capture outputs; stays in DONE.
  task automatic run_conv(input logic [31:0] fp, output logic [31:0] res,
                          output logic [2:0] fl, output int lat);
    @(negedge clk);
    fp_in    = fp;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    fp_in    = 32'hDEAD_BEEF;
    chk("in_ready_low_after_accept", {31'd0, in_ready}, 32'd0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    res = result;
    fl  = {Exception, Overflow, Underflow};
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("out_valid_falls", {31'd0, out_valid}, 32'd0);
    chk("in_ready_back", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] r;
    logic [2:0]  f;
    int          l;
    logic        spurious;

    total = 0;
    bad   = 0;

    vecs[0]  = '{32'h3F80_0000, 32'h0000_0001, 3'b000, 24};
    vecs[1]  = '{32'hC0A0_0000, 32'hFFFF_FFFB, 3'b000, 22};
    vecs[2]  = '{32'h4E80_0000, 32'h4000_0000, 3'b000, 8};
    vecs[3]  = '{32'h4B80_0001, 32'h0100_0002, 3'b000, 2};
    vecs[4]  = '{32'hCF00_0000, 32'h8000_0000, 3'b000, 1};
    vecs[5]  = '{32'h4F00_0000, 32'h7FFF_FFFF, 3'b010, 1};
    vecs[6]  = '{32'hFF80_0000, 32'h8000_0000, 3'b110, 1};
    vecs[7]  = '{32'h7FC0_0000, 32'h0000_0000, 3'b100, 1};
    vecs[8]  = '{32'h3F40_0000, 32'h0000_0000, 3'b001, 1};
    vecs[9]  = '{32'h0000_0001, 32'h0000_0000, 3'b001, 1};
    vecs[10] = '{32'h8000_0000, 32'h0000_0000, 3'b000, 1};
    vecs[11] = '{32'h7F80_0000, 32'h7FFF_FFFF, 3'b110, 1};
    vecs[12] = '{32'h4B00_0000, 32'h0080_0000, 3'b000, 1};
    vecs[13] = '{32'h42F7_0000, 32'h0000_007B, 3'b000, 18};
    vecs[14] = '{32'hC2F7_0000, 32'hFFFF_FF85, 3'b000, 18};
    vecs[15] = '{32'hCF00_0001, 32'h8000_0000, 3'b010, 1};
    vecs[16] = '{32'h4EFF_FFFF, 32'h7FFF_FF80, 3'b000, 8};

    rst       = 1'b1;
    fp_in     = 32'h0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_flags", {29'd0, Exception, Overflow, Underflow}, 32'd0);

    for (int i = 0; i < 17; i++) begin
      run_conv(vecs[i].fp, r, f, l);
      chk($sformatf("vec%0d_result", i), r, vecs[i].res);
      chk($sformatf("vec%0d_flags", i), {29'd0, f}, {29'd0, vecs[i].flags});
      chk($sformatf("vec%0d_latency", i), l, vecs[i].lat);
      handshake();
    end

    // Stalled consumer: outputs must hold while out_ready stays low.
    run_conv(32'hC0A0_0000, r, f, l);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("stall_result", result, 32'hFFFF_FFFB);
      chk("stall_flags", {29'd0, Exception, Overflow, Underflow}, 32'd0);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
    end
    handshake();

    // Reset during SHIFT aborts the conversion.
    @(negedge clk);
    fp_in    = 32'h3F80_0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_flags", {29'd0, Exception, Overflow, Underflow}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    spurious = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) spurious = 1'b1;
    end
    chk("abort_no_spurious_valid", {31'd0, spurious}, 32'd0);

    run_conv(32'h3F80_0000, r, f, l);
    chk("post_abort_result", r, 32'd1);
    chk("post_abort_flags", {29'd0, f}, 32'd0);
    chk("post_abort_latency", l, 24);
    handshake();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
